// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Widths, stream constants and the loader state encoding.
package imem_loader_pkg;

    // Instruction memory address width (matches the PC width).
    localparam int ADDR_W  = 8;

    // Instruction word width: {HI[0], LO}.
    localparam int INSTR_W = 9;

    // Bits of the HI byte that must be zero in a well-formed stream.
    localparam logic [7:0] HI_RSVD_MASK = 8'hFE;

    // Loader states.
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WR   = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    // States in which a stream byte may be accepted.
    function automatic logic accepts_byte(input state_e s);
        return (s == S_HDR) || (s == S_LO) ||
               (s == S_HI)  || (s == S_CSUM);
    endfunction

    // Assemble an instruction word from its LO and HI bytes.
    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return {hi[0], lo};
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a header/words/checksum byte stream,
// writes instruction memory from address 0 and holds the CPU in reset until done.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W-1:0] words_loaded
);

    state_e               state_q, state_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 load_done_q, load_done_d;
    logic                 load_error_q, load_error_d;
    logic [ADDR_W-1:0]    words_q, words_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           lo_q, lo_d;
    logic                 xfer;

    assign xfer = rx_valid & rx_ready_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        words_d      = words_q;
        csum_d       = csum_q;
        count_d      = count_q;
        lo_d         = lo_q;

        unique case (state_q)
            S_HDR: begin
                if (xfer) begin
                    csum_d  = rx_data;
                    count_d = rx_data;
                    state_d = (rx_data == 8'd0) ? S_CSUM : S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    if ((rx_data & HI_RSVD_MASK) != 8'd0) begin
                        load_error_d = 1'b1;
                        state_d      = S_ERR;
                    end else begin
                        csum_d       = csum_q ^ rx_data;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = words_q;
                        imem_wdata_d = make_instr(lo_q, rx_data);
                        state_d      = S_WR;
                    end
                end
            end
            S_WR: begin
                words_d = words_q + 1'b1;
                count_d = count_q - 8'd1;
                state_d = (count_q == 8'd1) ? S_CSUM : S_LO;
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    cpu_reset_d  = 1'b1;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    words_d      = '0;
                    csum_d       = 8'd0;
                    count_d      = 8'd0;
                    state_d      = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        rx_ready_d = accepts_byte(state_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HDR;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            words_q      <= '0;
            csum_q       <= 8'd0;
            count_q      <= 8'd0;
            lo_q         <= 8'd0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            words_q      <= words_d;
            csum_q       <= csum_d;
            count_q      <= count_d;
            lo_q         <= lo_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;

endmodule
